// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: state encoding and the
// default word width.
package uart_pkg;

  localparam int DEFAULT_WORD_BITS = 8;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_START = 2'd2;
  localparam logic [1:0] ST_WAIT  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GRANT = ST_GRANT,
    START = ST_START,
    WAIT  = ST_WAIT
  } arb_state_t;

endpackage

// File: rtl/uart_rr_pick2.sv
// Combinational two-way round-robin pick: with both requesters valid, the one
// that did not own the transmitter last time wins.
module uart_rr_pick2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic       any,
  output logic       index
);

  always_comb begin
    any = |valid;
    if (&valid) begin
      index = ~last_grant;
    end else begin
      index = valid[1];
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares one UART transmitter between the echo FIFO (requester 0) and the
// Morse/status source (requester 1), with a watchdog on the done handshake.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int WORD_BITS     = DEFAULT_WORD_BITS,
  parameter int TIMEOUT_LIMIT = 1048576,
  parameter int TIMEOUT_BITS  = 21
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 req0_valid_i,
  input  logic [WORD_BITS-1:0] req0_data_i,
  output logic                 req0_ack_o,
  input  logic                 req1_valid_i,
  input  logic [WORD_BITS-1:0] req1_data_i,
  output logic                 req1_ack_o,
  output logic                 tx_start_o,
  output logic [WORD_BITS-1:0] tx_data_o,
  input  logic                 tx_done_i,
  output logic                 busy_o,
  output logic                 grant_o,
  output logic                 timeout_o
);

  localparam logic [TIMEOUT_BITS-1:0] WAIT_LAST = TIMEOUT_BITS'(TIMEOUT_LIMIT - 1);

  arb_state_t state, state_next;

  logic [TIMEOUT_BITS-1:0] wd_count, wd_count_next;
  logic [WORD_BITS-1:0]    data_next;
  logic                    ack0_next;
  logic                    ack1_next;
  logic                    start_next;
  logic                    timeout_next;
  logic                    busy_next;
  logic                    grant_next;
  logic                    pick_any;
  logic                    pick_index;

  uart_rr_pick2 u_pick (
    .valid      ({req1_valid_i, req0_valid_i}),
    .last_grant (grant_o),
    .any        (pick_any),
    .index      (pick_index)
  );

  // Every output is computed one cycle ahead here and registered below, so
  // the pulses and the busy flag line up with the state they belong to.
  always_comb begin
    state_next    = state;
    wd_count_next = wd_count;
    data_next     = tx_data_o;
    grant_next    = grant_o;
    ack0_next     = 1'b0;
    ack1_next     = 1'b0;
    start_next    = 1'b0;
    timeout_next  = 1'b0;

    case (state)
      IDLE: begin
        if (pick_any) begin
          state_next = GRANT;
          grant_next = pick_index;
          data_next  = pick_index ? req1_data_i : req0_data_i;
          ack0_next  = ~pick_index;
          ack1_next  = pick_index;
        end
      end
      GRANT: begin
        state_next = START;
        start_next = 1'b1;
      end
      START: begin
        state_next    = WAIT;
        wd_count_next = '0;
      end
      WAIT: begin
        // A done always wins over an abort landing on the same edge.
        if (tx_done_i) begin
          state_next = IDLE;
        end else if (wd_count == WAIT_LAST) begin
          state_next   = IDLE;
          timeout_next = 1'b1;
        end else begin
          wd_count_next = wd_count + TIMEOUT_BITS'(1);
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state      <= IDLE;
      wd_count   <= '0;
      tx_data_o  <= '0;
      grant_o    <= 1'b1;
      req0_ack_o <= 1'b0;
      req1_ack_o <= 1'b0;
      tx_start_o <= 1'b0;
      timeout_o  <= 1'b0;
      busy_o     <= 1'b0;
    end else begin
      state      <= state_next;
      wd_count   <= wd_count_next;
      tx_data_o  <= data_next;
      grant_o    <= grant_next;
      req0_ack_o <= ack0_next;
      req1_ack_o <= ack1_next;
      tx_start_o <= start_next;
      timeout_o  <= timeout_next;
      busy_o     <= busy_next;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Scoreboard bench for uart_tx_arbiter: a transaction-level model predicts
// acks, start pulses and timeouts by edge number; a monitor compares them.
module tb_uart_tx_arbiter;

  localparam int LIM    = 64;
  localparam int LIM_TO = 16;

  typedef struct {
    int         at;
    bit         idx;
    logic [7:0] data;
  } ack_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       v0 = 1'b0, v1 = 1'b0;
  logic [7:0] d0 = '0, d1 = '0;
  logic       tx_done = 1'b0;

  logic       ack0_w, ack1_w, start_w, busy_w, grant_w, to_w;
  logic [7:0] data_w;

  logic       to_v0 = 1'b0, to_v1 = 1'b0, to_done = 1'b0;
  logic [7:0] to_d0 = '0, to_d1 = '0;
  logic       to_ack0, to_ack1, to_start, to_busy, to_grant, to_timeout;
  logic [7:0] to_data;

  int   e = 0;
  int   checks = 0;
  int   errors = 0;

  bit         in_flight = 1'b0;
  bit         m_last = 1'b1;
  logic [7:0] m_data = '0;
  int         g_edge = 0;
  ack_t       ackq[$];
  int         startq[$];
  int         toq[$];

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  int         gate0 = 100, gate1 = 100;
  int         done_mode = 0;
  int         done_fix = 5;
  bit         spur = 1'b0;
  bit         done_req = 1'b0;
  int         done_at = -1;

  logic [1:0] exp_ack;
  logic       exp_st, exp_to;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .WORD_BITS     (8),
    .TIMEOUT_LIMIT (LIM),
    .TIMEOUT_BITS  (7)
  ) dut (
    .clk_i        (clk),
    .reset_i      (rst_n),
    .req0_valid_i (v0),
    .req0_data_i  (d0),
    .req0_ack_o   (ack0_w),
    .req1_valid_i (v1),
    .req1_data_i  (d1),
    .req1_ack_o   (ack1_w),
    .tx_start_o   (start_w),
    .tx_data_o    (data_w),
    .tx_done_i    (tx_done),
    .busy_o       (busy_w),
    .grant_o      (grant_w),
    .timeout_o    (to_w)
  );

  uart_tx_arbiter #(
    .WORD_BITS     (8),
    .TIMEOUT_LIMIT (LIM_TO),
    .TIMEOUT_BITS  (5)
  ) dut_to (
    .clk_i        (clk),
    .reset_i      (rst_n),
    .req0_valid_i (to_v0),
    .req0_data_i  (to_d0),
    .req0_ack_o   (to_ack0),
    .req1_valid_i (to_v1),
    .req1_data_i  (to_d1),
    .req1_ack_o   (to_ack1),
    .tx_start_o   (to_start),
    .tx_data_o    (to_data),
    .tx_done_i    (to_done),
    .busy_o       (to_busy),
    .grant_o      (to_grant),
    .timeout_o    (to_timeout)
  );

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at edge %0d", name, act, exp, e);
    end
  endtask

  // Reference model: edge-numbered view of the arbiter. A grant at edge g
  // means ack after g, start after g+1, done accepted from edge g+3 on, and
  // an abort at edge g+2+LIM if no done arrived.
  initial begin
    forever begin
      @(posedge clk);
      e++;
      if (!rst_n) begin
        in_flight = 1'b0;
        m_last    = 1'b1;
        m_data    = '0;
        ackq.delete();
        startq.delete();
        toq.delete();
      end else if (in_flight) begin
        if (e >= g_edge + 3 && tx_done) begin
          in_flight = 1'b0;
        end else if (e == g_edge + 2 + LIM) begin
          in_flight = 1'b0;
          toq.push_back(e);
        end
      end else if (v0 || v1) begin
        bit idx;
        idx       = (v0 && v1) ? !m_last : v1;
        m_last    = idx;
        m_data    = idx ? d1 : d0;
        in_flight = 1'b1;
        g_edge    = e;
        ackq.push_back('{at: e, idx: idx, data: m_data});
        startq.push_back(e + 1);
      end
    end
  end

  // Monitor: pops expectations scheduled for this edge and compares.
  initial begin
    forever begin
      @(negedge clk);
      if (e > 0) begin
        exp_ack = 2'b00;
        exp_st  = 1'b0;
        exp_to  = 1'b0;
        if (ackq.size() > 0 && ackq[0].at == e) begin
          exp_ack = ackq[0].idx ? 2'b10 : 2'b01;
          check_output("ack_data", data_w, ackq[0].data);
          void'(ackq.pop_front());
        end
        if (startq.size() > 0 && startq[0] == e) begin
          exp_st = 1'b1;
          void'(startq.pop_front());
        end
        if (toq.size() > 0 && toq[0] == e) begin
          exp_to = 1'b1;
          void'(toq.pop_front());
        end
        check_output("ack", {ack1_w, ack0_w}, exp_ack);
        check_output("tx_start", start_w, exp_st);
        check_output("timeout", to_w, exp_to);
        check_output("busy", busy_w, in_flight);
        check_output("grant", grant_w, m_last);
        check_output("tx_data", data_w, m_data);
      end
    end
  end

  // Requester and transmitter emulation for the main instance.
  initial begin
    forever begin
      @(negedge clk);
      tx_done = 1'b0;
      if (ack0_w && v0 && src0.size() > 0) begin
        void'(src0.pop_front());
        v0 = 1'b0;
      end
      if (ack1_w && v1 && src1.size() > 0) begin
        void'(src1.pop_front());
        v1 = 1'b0;
      end
      if (!v0 && src0.size() > 0 && $urandom_range(99) < gate0) begin
        v0 = 1'b1;
        d0 = src0[0];
      end
      if (!v1 && src1.size() > 0 && $urandom_range(99) < gate1) begin
        v1 = 1'b1;
        d1 = src1[0];
      end
      if (!v0) d0 = 8'($urandom);
      if (!v1) d1 = 8'($urandom);
      if (start_w) begin
        if (done_mode == 0) done_at = e + done_fix;
        else if (done_mode == 1) done_at = ($urandom_range(9) == 0) ? -1 : e + int'($urandom_range(40, 1));
        else done_at = -1;
        if (spur) tx_done = 1'b1;
      end
      if (spur && !busy_w && $urandom_range(3) == 0) tx_done = 1'b1;
      if (e == done_at) tx_done = 1'b1;
      if (done_req) begin
        tx_done  = 1'b1;
        done_req = 1'b0;
      end
    end
  end

  task automatic drain(input int budget);
    int n;
    n = 0;
    while ((src0.size() > 0 || src1.size() > 0 || v0 || v1 || in_flight) && n < budget) begin
      @(negedge clk);
      n++;
    end
    check_output("drain_done", n < budget, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic apply_stimulus();
    int n;
    // Requester 0 alone, done twenty cycles after start.
    gate0 = 100; gate1 = 100; done_mode = 0; done_fix = 20; spur = 1'b0;
    src0.push_back(8'h41);
    drain(300);

    // Both requesters valid straight out of reset: strict alternation.
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    done_fix = 5;
    for (int i = 0; i < 3; i++) begin
      src0.push_back(8'hAA);
      src1.push_back(8'h55);
    end
    drain(500);

    // Requester 1 streaming three words back to back.
    done_fix = 3;
    src1.push_back(8'h01);
    src1.push_back(8'h02);
    src1.push_back(8'h03);
    drain(300);

    // Reset while waiting on the transmitter, then a stale done.
    done_mode = 2;
    src0.push_back(8'h77);
    n = 0;
    while (!(in_flight && e >= g_edge + 5) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check_output("reach_wait", n < 100, 1);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    done_req = 1'b1;
    repeat (4) @(negedge clk);
    done_mode = 0; done_fix = 4;
    src0.push_back(8'h10);
    src1.push_back(8'h20);
    drain(300);

    // Dones in IDLE and coincident with the start pulse.
    spur = 1'b1; done_fix = 10;
    src0.push_back(8'h3C);
    src1.push_back(8'hC3);
    drain(300);

    // Randomized traffic with occasional silent transmitters.
    done_mode = 1; gate0 = 30; gate1 = 30;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(1) == 0) src0.push_back(8'($urandom));
      else src1.push_back(8'($urandom));
    end
    drain(20000);
    spur = 1'b0;
  endtask

  // Watchdog abort on the small-limit instance, pending valid granted next.
  task automatic watchdog_test();
    int n;
    int ge;
    to_v0 = 1'b1;
    to_d0 = 8'h33;
    n = 0;
    while (!to_ack0 && n < 10) begin
      @(negedge clk);
      n++;
    end
    check_output("to_first_ack", to_ack0, 1);
    ge = e;
    to_v0 = 1'b0;
    to_v1 = 1'b1;
    to_d1 = 8'h5A;
    for (int k = 0; k < 18; k++) begin
      @(negedge clk);
      check_output("to_pulse", to_timeout, (e == ge + 2 + LIM_TO));
    end
    check_output("to_busy_idle", to_busy, 0);
    @(negedge clk);
    check_output("to_next_ack1", to_ack1, 1);
    check_output("to_next_grant", to_grant, 1);
    check_output("to_next_data", to_data, 8'h5A);
    check_output("to_pulse_gone", to_timeout, 0);
    to_v1 = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    apply_stimulus();
    watchdog_test();
    check_output("ackq_empty", ackq.size(), 0);
    check_output("startq_empty", startq.size(), 0);
    check_output("toq_empty", toq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL global_timeout: simulation did not complete, edge %0d", e);
    $fatal(1, "[TB] global timeout");
  end

endmodule

// File: doc/uart_tx_arbiter.md
Name: uart_tx_arbiter

Overview:
- Shares one uart_transmitter between two byte requesters: requester 0 is the echo path tx FIFO, requester 1 is the Morse/status message source.
- Performs round-robin arbitration and latches the granted word.
- Sequences the transmitter's start/done handshake.
- Recovers from a transmitter that never reports done, using a watchdog.

Parameters:
- WORD_BITS, 8, bits per data word
- TIMEOUT_LIMIT, 1048576, clock cycles allowed in WAIT before abort (>= one full frame at lowest baud)
- TIMEOUT_BITS, 21, counter width; must satisfy 2^TIMEOUT_BITS > TIMEOUT_LIMIT

Ports:
- clk_i  in  1  clock
- reset_i  in  1  reset; synchronous, active-low (0 = reset)
- req0_valid_i  in  1  requester 0 has a word
- req0_data_i  in  WORD_BITS  requester 0 word; stable while valid
- req0_ack_o  out  1  one-cycle pulse: word accepted (pop strobe)
- req1_valid_i  in  1  requester 1 has a word
- req1_data_i  in  WORD_BITS  requester 1 word
- req1_ack_o  out  1  one-cycle pulse: word accepted
- tx_start_o  out  1  one-cycle start pulse to transmitter
- tx_data_o  out  WORD_BITS  latched word; held from GRANT until next grant
- tx_done_i  in  1  transmitter done pulse
- busy_o  out  1  high in any state except IDLE
- grant_o  out  1  index of current/last owner
- timeout_o  out  1  one-cycle pulse on watchdog abort

Behaviour:
- All outputs are registered.
- Reset (reset_i=0 sampled at a rising edge) applies the following; reset mid-operation aborts the transfer with no ack and no start pulse.
  - state=IDLE
  - all acks, tx_start_o, busy_o and timeout_o = 0
  - tx_data_o = 0
  - grant_o = 1, so requester 0 wins the first contention
  - watchdog counter = 0
- FSM states: IDLE, GRANT, START, WAIT.
- IDLE:
  - Sample both valids. If neither is valid, stay.
  - If exactly one is valid, pick it.
  - If both are valid, pick the index != grant_o.
  - Next state: GRANT. In the same edge:
    - tx_data_o <= picked data
    - grant_o <= picked index
    - req<picked>_ack_o <= 1 for exactly one cycle
- GRANT: go to START; tx_start_o <= 1 for one cycle.
- START: go to WAIT; watchdog counter <= 0.
- WAIT:
  - tx_done_i=1 -> IDLE.
  - Else counter increments. At counter == TIMEOUT_LIMIT-1 -> IDLE and timeout_o <= 1 for one cycle.
  - No ack is reissued and the word is dropped.
- Latency: valid sampled in IDLE at edge n -> ack visible cycle n+1 -> tx_start_o visible cycle n+2.
- Back-to-back: done at edge m -> IDLE; the next grant is decided at edge m+1. Minimum gap is 2 cycles between done and the next start pulse.
- tx_done_i is ignored outside WAIT, including a done coincident with tx_start_o and spurious pulses in IDLE.
- A valid dropped before being sampled in IDLE is not granted. Valids are ignored outside IDLE.
- Exactly one ack pulse per granted word. Acks are mutually exclusive.
- busy_o = (state != IDLE), registered with the state.

Decomposition:
- Shared package uart_pkg:
  - state encoding localparams (ST_IDLE, ST_GRANT, ST_START, ST_WAIT, 2-bit)
  - default WORD_BITS
- One sub-module, uart_rr_pick2:
  - combinational 2-way round-robin pick
  - inputs: valid[1:0], last grant
  - outputs: any, index

Test Plan:
- Requester 0 only, data 0x41; done pulsed 20 cycles after start:
  - req0_ack_o one cycle after valid, then tx_start_o, with tx_data_o=0x41
  - busy_o low on the cycle after done
  - req1_ack_o never asserted
- Both valid from reset, data 0xAA/0x55, each held until its ack:
  - grants in order req0, req1, req0, ... (grant_o toggles)
  - tx_data_o alternates 0xAA, 0x55
- Requester 1 continuously valid (3 words 0x01,0x02,0x03), requester 0 idle:
  - three consecutive req1 grants
  - exactly 2 cycles between each done and the next tx_start_o
- TIMEOUT_LIMIT=16, tx_done_i never asserted:
  - timeout_o pulses once, exactly 16 cycles after entering WAIT
  - FSM returns to IDLE; a pending valid is granted next
- reset_i=0 held one cycle while in WAIT:
  - all outputs at reset values next cycle
  - a later tx_done_i pulse causes no state change
  - first contention grants req0
- tx_done_i pulsed in IDLE and in the same cycle as tx_start_o:
  - both pulses ignored; FSM remains in WAIT until a later done
